// File: rtl/pipe_enq_arbiter.sv
// Round-robin arbiter sharing one pipe enqueue channel among NREQ requesters,
// with a one-entry output register, source tagging and per-source counters.
module pipe_enq_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 192,
    parameter int unsigned SRCW = 2,
    parameter int unsigned CNTW = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      req_enq_ena,
    input  logic [NREQ*W-1:0]    req_enq_v,
    output logic [NREQ-1:0]      req_enq_rdy_c,
    output logic                 pipe_enq_ena,
    output logic [W-1:0]         pipe_enq_v,
    output logic [SRCW-1:0]      pipe_enq_src,
    input  logic                 pipe_enq_rdy,
    output logic [NREQ*CNTW-1:0] stat_count
);

    localparam int unsigned LAST_RST = NREQ - 1;

    logic            valid;
    logic [SRCW-1:0] last;
    logic [CNTW-1:0] cnt [NREQ];

    logic [SRCW-1:0] grant;
    logic [SRCW-1:0] idx;
    logic            any_req;
    logic            space;
    logic            accept;

    // Rotating priority search starting just after the last granted source.
    always_comb begin
        grant   = '0;
        idx     = '0;
        any_req = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = SRCW'((32'(last) + k) % NREQ);
            if (!any_req && req_enq_ena[idx]) begin
                any_req = 1'b1;
                grant   = idx;
            end
        end
    end

    assign space         = !valid || pipe_enq_rdy;
    assign accept        = space && any_req && !RST;
    assign req_enq_rdy_c = accept ? (NREQ'(1) << grant) : '0;

    assign pipe_enq_ena = valid;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid        <= 1'b0;
            pipe_enq_v   <= '0;
            pipe_enq_src <= '0;
            last         <= SRCW'(LAST_RST);
            for (int unsigned i = 0; i < NREQ; i++) begin
                cnt[i] <= '0;
            end
        end else if (accept) begin
            // Load may coincide with a drain of the previous message.
            valid        <= 1'b1;
            pipe_enq_v   <= req_enq_v[32'(grant)*W +: W];
            pipe_enq_src <= grant;
            last         <= grant;
            cnt[grant]   <= cnt[grant] + CNTW'(1);
        end else if (valid && pipe_enq_rdy) begin
            valid <= 1'b0;
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_stat
        assign stat_count[g*CNTW +: CNTW] = cnt[g];
    end

endmodule
